// File: rtl/spi_master_engine.sv
// Self-timed SPI initiator: one 16-bit mode-0 frame {addr, rw, data} per start,
// SCLK/CS derived from clk with HALF clk cycles per SCLK half-period.
module spi_master_engine #(
    parameter int HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       miso,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    output logic       mosi_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    localparam logic [7:0] HALF_M1 = 8'(HALF - 1);

    // Reads carry an all-zero data byte so the released bus never leaks wdata.
    function automatic logic [15:0] build_frame(input logic [6:0] a, input logic r, input logic [7:0] w);
        build_frame = {a, r, (r ? 8'h00 : w)};
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [15:0] frame_q, frame_d;
    logic        rw_q, rw_d;
    logic [7:0]  rx_q, rx_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        half_end_s;
    logic [3:0]  bit_idx_s;
    logic        next_oe_s;
    logic        next_mosi_s;

    assign half_end_s  = (hcnt_q == HALF_M1);
    // After rise k the next wire bit is frame[15-k]; the data byte is released on reads.
    assign bit_idx_s   = 4'd15 - bitcnt_q[3:0];
    assign next_oe_s   = bit_idx_s[3] | ~rw_q;
    assign next_mosi_s = next_oe_s & frame_q[bit_idx_s];

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q + 8'd1;
        bitcnt_d = bitcnt_q;
        frame_d  = frame_q;
        rw_d     = rw_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                hcnt_d   = 8'd0;
                bitcnt_d = 5'd0;
                sclk_d   = 1'b0;
                if (start) begin
                    frame_d = build_frame(addr, rw, wdata);
                    rw_d    = rw;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = addr[6];
                    oe_d    = 1'b1;
                    state_d = S_SETUP;
                end else begin
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                    oe_d    = 1'b0;
                end
            end
            S_SETUP, S_LOW: begin
                if (half_end_s) begin
                    state_d  = S_HIGH;
                    hcnt_d   = 8'd0;
                    sclk_d   = 1'b1;
                    // Only the last eight samples form rdata, so eight bits suffice.
                    rx_d     = {rx_q[6:0], miso};
                    bitcnt_d = bitcnt_q + 5'd1;
                end else begin
                    state_d  = state_q;
                end
            end
            S_HIGH: begin
                if (half_end_s) begin
                    hcnt_d = 8'd0;
                    sclk_d = 1'b0;
                    if (bitcnt_q == 5'd16) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        mosi_d  = next_mosi_s;
                        oe_d    = next_oe_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_HOLD: begin
                if (half_end_s) begin
                    state_d = S_DONE;
                    cs_n_d  = 1'b1;
                    oe_d    = 1'b0;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                hcnt_d  = 8'd0;
            end
            S_GAP: begin
                if (half_end_s) begin
                    state_d = S_IDLE;
                    hcnt_d  = 8'd0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                hcnt_d  = 8'd0;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hcnt_q   <= 8'd0;
            bitcnt_q <= 5'd0;
            frame_q  <= 16'h0000;
            rw_q     <= 1'b0;
            rx_q     <= 8'h00;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            bitcnt_q <= bitcnt_d;
            frame_q  <= frame_d;
            rw_q     <= rw_d;
            rx_q     <= rx_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end

    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;
    assign mosi_oe = oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Randomized self-checking bench: two engines (HALF=4 and HALF=1) against a
// wire-level reference of frame contents, edge timing and rdata.
module tb_spi_master_engine;

    logic        clk = 1'b0;
    int unsigned cyc = 0;

    logic [1:0]  rst_n_r  = 2'b00;
    logic [1:0]  start_r  = 2'b00;
    logic [1:0]  rw_r     = 2'b00;
    logic [1:0]  miso_r   = 2'b00;
    logic [6:0]  addr_r  [2];
    logic [7:0]  wdata_r [2];

    logic [1:0]  sclk_w, cs_n_w, mosi_w, oe_w, busy_w, done_w;
    logic [7:0]  rdata_w [2];

    int          half_v [2];
    logic [7:0]  exp_rdata [2];
    logic [7:0]  rbyte [2];

    // monitor state
    logic [1:0]  prev_sclk = 2'b00;
    logic [1:0]  prev_cs   = 2'b11;
    logic [1:0]  prev_busy = 2'b00;
    int          nrise [2], e0 [2], cs_rise [2], last_gap [2];
    int          ndone [2], done_cyc [2], busy_fall [2];
    int          rise_cyc [2][16];
    logic [15:0] wire_bits [2], oe_bits [2];

    int          n_checks = 0;
    int          n_fail   = 0;

    spi_master_engine #(.HALF(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n_r[0]), .start(start_r[0]), .rw(rw_r[0]),
        .addr(addr_r[0]), .wdata(wdata_r[0]), .miso(miso_r[0]),
        .sclk(sclk_w[0]), .cs_n(cs_n_w[0]), .mosi(mosi_w[0]), .mosi_oe(oe_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0])
    );

    spi_master_engine #(.HALF(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n_r[1]), .start(start_r[1]), .rw(rw_r[1]),
        .addr(addr_r[1]), .wdata(wdata_r[1]), .miso(miso_r[1]),
        .sclk(sclk_w[1]), .cs_n(cs_n_w[1]), .mosi(mosi_w[1]), .mosi_oe(oe_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wire monitor and responder model, sampled on the falling clk edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (prev_cs[d] === 1'b1 && cs_n_w[d] === 1'b0) begin
                e0[d]       <= int'(cyc);
                nrise[d]    <= 0;
                last_gap[d] <= int'(cyc) - cs_rise[d];
            end
            if (prev_cs[d] === 1'b0 && cs_n_w[d] === 1'b1) cs_rise[d] <= int'(cyc);
            if (prev_sclk[d] === 1'b0 && sclk_w[d] === 1'b1) begin
                if (nrise[d] < 16) rise_cyc[d][nrise[d]] <= int'(cyc);
                wire_bits[d] <= {wire_bits[d][14:0], mosi_w[d]};
                oe_bits[d]   <= {oe_bits[d][14:0], oe_w[d]};
                nrise[d]     <= nrise[d] + 1;
            end
            if (prev_sclk[d] === 1'b1 && sclk_w[d] === 1'b0) begin
                if (nrise[d] >= 8 && nrise[d] < 16) miso_r[d] <= rbyte[d][3'(15 - nrise[d])];
                else                                miso_r[d] <= 1'($urandom_range(0, 1));
            end
            if (done_w[d] === 1'b1) begin
                ndone[d]    <= ndone[d] + 1;
                done_cyc[d] <= int'(cyc);
            end
            if (prev_busy[d] === 1'b1 && busy_w[d] === 1'b0) busy_fall[d] <= int'(cyc);
            prev_cs[d]   <= cs_n_w[d];
            prev_sclk[d] <= sclk_w[d];
            prev_busy[d] <= busy_w[d];
        end
    end

    task automatic tick(input int d);
        @(negedge clk);
        #1;
    endtask

    // Frame content and rise timing of the most recent frame against the reference.
    task automatic check_frame(input int d, input string tag, input logic [6:0] a,
                               input logic r, input logic [7:0] w);
        int bad;
        int h;
        h = half_v[d];
        check_val({tag, "/wire"}, wire_bits[d], {a, r, (r ? 8'h00 : w)});
        check_val({tag, "/oe"}, oe_bits[d], r ? 16'hFF00 : 16'hFFFF);
        check_val({tag, "/nrise"}, nrise[d], 16);
        bad = 0;
        for (int k = 0; k < 16; k++) if (rise_cyc[d][k] - e0[d] != (2 * k + 1) * h) bad++;
        check_val({tag, "/rise_times"}, bad, 0);
        check_val({tag, "/done_time"}, done_cyc[d] - e0[d], 33 * h);
    endtask

    task automatic wait_done(input int d, input int nd_target, input int glitch1,
                             input int glitch2, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 * half_v[d] + 40 && !got; i++) begin
            start_r[d] = (i == glitch1 || i == glitch2) ? 1'b1 : 1'b0;
            tick(d);
            if (ndone[d] >= nd_target) got = 1'b1;
        end
        start_r[d] = 1'b0;
    endtask

    task automatic run_txn(input int d, input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic [7:0] rb, input int glitch1, input int glitch2,
                           input string tag);
        int nd0;
        bit got;
        tick(d);
        addr_r[d] = a; rw_r[d] = r; wdata_r[d] = w; rbyte[d] = rb;
        start_r[d] = 1'b1;
        nd0 = ndone[d];
        tick(d);
        start_r[d] = 1'b0;
        addr_r[d] = 7'($urandom); rw_r[d] = 1'($urandom); wdata_r[d] = 8'($urandom);
        wait_done(d, nd0 + 1, glitch1, glitch2, got);
        check_val({tag, "/done_seen"}, got, 1);
        for (int i = 0; i < 2 * half_v[d] + 8 && busy_w[d] === 1'b1; i++) tick(d);
        check_val({tag, "/busy_low"}, busy_w[d], 0);
        check_frame(d, tag, a, r, w);
        check_val({tag, "/busy_time"}, busy_fall[d] - e0[d], 34 * half_v[d] + 1);
        if (r) exp_rdata[d] = rb;
        check_val({tag, "/rdata"}, rdata_w[d], exp_rdata[d]);
        repeat (2 * half_v[d] + 4) tick(d);
        check_val({tag, "/one_done"}, ndone[d] - nd0, 1);
        check_val({tag, "/idle_cs"}, cs_n_w[d], 1);
    endtask

    task automatic run_b2b(input int d, input logic [6:0] a1, input logic r1, input logic [7:0] w1,
                           input logic [7:0] rb1, input logic [6:0] a2, input logic r2,
                           input logic [7:0] w2, input logic [7:0] rb2, input string tag);
        int nd0;
        bit got;
        tick(d);
        addr_r[d] = a1; rw_r[d] = r1; wdata_r[d] = w1; rbyte[d] = rb1;
        start_r[d] = 1'b1;
        nd0 = ndone[d];
        tick(d);
        addr_r[d] = a2; rw_r[d] = r2; wdata_r[d] = w2;
        got = 1'b0;
        for (int i = 0; i < 40 * half_v[d] + 40 && !got; i++) begin
            tick(d);
            if (ndone[d] > nd0) got = 1'b1;
        end
        check_val({tag, "/done1_seen"}, got, 1);
        check_frame(d, {tag, "/f1"}, a1, r1, w1);
        if (r1) exp_rdata[d] = rb1;
        check_val({tag, "/rdata1"}, rdata_w[d], exp_rdata[d]);
        rbyte[d] = rb2;
        for (int i = 0; i < 4 * half_v[d] + 8 && cs_n_w[d] === 1'b1; i++) tick(d);
        start_r[d] = 1'b0;
        check_val({tag, "/gap"}, last_gap[d], half_v[d] + 2);
        got = 1'b0;
        for (int i = 0; i < 40 * half_v[d] + 40 && !got; i++) begin
            tick(d);
            if (ndone[d] > nd0 + 1) got = 1'b1;
        end
        check_val({tag, "/done2_seen"}, got, 1);
        check_frame(d, {tag, "/f2"}, a2, r2, w2);
        for (int i = 0; i < 2 * half_v[d] + 8 && busy_w[d] === 1'b1; i++) tick(d);
        if (r2) exp_rdata[d] = rb2;
        check_val({tag, "/rdata2"}, rdata_w[d], exp_rdata[d]);
        repeat (2 * half_v[d] + 4) tick(d);
        check_val({tag, "/two_done"}, ndone[d] - nd0, 2);
    endtask

    task automatic run_reset(input int d);
        int nd0;
        bit hit;
        tick(d);
        addr_r[d] = 7'($urandom); rw_r[d] = 1'b0; wdata_r[d] = 8'($urandom);
        start_r[d] = 1'b1;
        nd0 = ndone[d];
        tick(d);
        start_r[d] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 * half_v[d] + 20 && !hit; i++) begin
            tick(d);
            if (nrise[d] == 5) hit = 1'b1;
        end
        check_val("rst/fifth_rise", hit, 1);
        rst_n_r[d] = 1'b0;
        tick(d);
        check_val("rst/cs_n", cs_n_w[d], 1);
        check_val("rst/sclk", sclk_w[d], 0);
        check_val("rst/busy", busy_w[d], 0);
        check_val("rst/mosi_oe", oe_w[d], 0);
        check_val("rst/rdata", rdata_w[d], 0);
        exp_rdata[d] = 8'h00;
        rst_n_r[d] = 1'b1;
        repeat (40 * half_v[d]) tick(d);
        check_val("rst/no_done", ndone[d] - nd0, 0);
    endtask

    initial begin
        half_v[0] = 4; half_v[1] = 1;
        for (int d = 0; d < 2; d++) begin
            addr_r[d] = 7'h00; wdata_r[d] = 8'h00; exp_rdata[d] = 8'h00; rbyte[d] = 8'h00;
            nrise[d] = 0; e0[d] = 0; cs_rise[d] = 0; last_gap[d] = 0;
            ndone[d] = 0; done_cyc[d] = 0; busy_fall[d] = 0;
            wire_bits[d] = 16'h0000; oe_bits[d] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val("reset/sclk", sclk_w[d], 0);
            check_val("reset/cs_n", cs_n_w[d], 1);
            check_val("reset/mosi", mosi_w[d], 0);
            check_val("reset/mosi_oe", oe_w[d], 0);
            check_val("reset/busy", busy_w[d], 0);
            check_val("reset/done", done_w[d], 0);
            check_val("reset/rdata", rdata_w[d], 0);
        end
        rst_n_r = 2'b11;

        run_txn(0, 7'h2A, 1'b0, 8'hC3, 8'h5A, -1, -1, "wr_2A");
        run_txn(0, 7'h05, 1'b1, 8'h77, 8'h96, -1, -1, "rd_05");
        run_reset(0);
        run_txn(0, 7'h11, 1'b0, 8'h3C, 8'h00, -1, -1, "after_rst");
        run_txn(0, 7'h33, 1'b1, 8'h00, 8'hA5, 4, 128, "glitch");
        run_b2b(0, 7'h41, 1'b0, 8'h81, 8'h00, 7'h62, 1'b1, 8'h00, 8'h3E, "b2b4");
        run_txn(1, 7'h7F, 1'b0, 8'hFF, 8'h00, -1, -1, "h1_wr_7F");
        run_b2b(1, 7'h0C, 1'b1, 8'h00, 8'hC9, 7'h55, 1'b0, 8'h6D, 8'h00, "b2b1");
        for (int n = 0; n < 4; n++)
            run_txn(0, 7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), -1, -1, "rand4");
        for (int n = 0; n < 4; n++)
            run_txn(1, 7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), -1, -1, "rand1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
